instruction_decode: RTL and testbench

Second pipeline stage of the 8-bit-PC / 16-bit-instruction processor. It takes the combinational fetch bundle (`IF_output`: PC in bits [7:0], instruction in bits [23:8]) and decodes the instruction into register addresses, an immediate and control flags. The decoded result is latched into the ID/EX output register. The block also detects load-use hazards, drives `data_stall` back to fetch, and inserts bubbles on stalls and on taken-branch flushes.

---
 rtl/instruction_decode.sv | 174 +++++++++++++++++
 tb/tb_instruction_decode.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// Instruction decode stage: decodes the fetch bundle into the ID/EX register,
// detects load-use hazards against the instruction held in ID/EX, and inserts
// bubbles on stalls and on taken-branch flushes.
module instruction_decode #(
    parameter int unsigned STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [23:0]            IF_output,
    input  logic                   branch_flush,
    output logic                   data_stall,
    output logic                   id_valid,
    output logic [7:0]             id_pc,
    output logic [3:0]             id_opcode,
    output logic [3:0]             id_rd,
    output logic [3:0]             id_rs1,
    output logic [3:0]             id_rs2,
    output logic [7:0]             id_imm,
    output logic                   id_reg_write,
    output logic                   id_mem_read,
    output logic                   id_mem_write,
    output logic                   id_is_branch,
    output logic                   id_illegal,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic [STALL_CNT_W-1:0] flush_count
);

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_LDI   = 4'h5,
        OP_LOAD  = 4'h6,
        OP_STORE = 4'h7,
        OP_JMP   = 4'h8,
        OP_BZ    = 4'h9
    } opcode_e;

    logic [15:0] instr;
    logic [7:0]  pc;
    opcode_e     op;

    logic dec_reg_write, dec_mem_read, dec_mem_write, dec_is_branch, dec_illegal;
    logic uses_rs1, uses_rs2, uses_rd;
    logic hazard;

    logic                   id_valid_q;
    logic [7:0]             id_pc_q;
    logic [3:0]             id_opcode_q, id_rd_q, id_rs1_q, id_rs2_q;
    logic [7:0]             id_imm_q;
    logic                   id_reg_write_q, id_mem_read_q, id_mem_write_q;
    logic                   id_is_branch_q, id_illegal_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    assign pc    = IF_output[7:0];
    assign instr = IF_output[23:8];
    assign op    = opcode_e'(instr[15:12]);

    // Decode control flags and which register fields the instruction reads
    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_is_branch = 1'b0;
        dec_illegal   = 1'b0;
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        uses_rd       = 1'b0;
        case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                dec_reg_write = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_LDI: dec_reg_write = 1'b1;
            OP_LOAD: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                uses_rs1      = 1'b1;
            end
            OP_STORE: begin
                dec_mem_write = 1'b1;
                uses_rs1      = 1'b1;
                uses_rd       = 1'b1;
            end
            OP_JMP: dec_is_branch = 1'b1;
            OP_BZ: begin
                dec_is_branch = 1'b1;
                uses_rd       = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Load-use hazard: a LOAD in ID/EX whose rd feeds a source the fetched instruction reads
    always_comb begin
        hazard = id_valid_q && id_mem_read_q && !branch_flush &&
                 ((uses_rs1 && (instr[7:4]  == id_rd_q)) ||
                  (uses_rs2 && (instr[3:0]  == id_rd_q)) ||
                  (uses_rd  && (instr[11:8] == id_rd_q)));
    end

    assign data_stall = hazard;

    // ID/EX register: flush bubble beats stall bubble beats normal latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q     <= 1'b0;
            id_pc_q        <= '0;
            id_opcode_q    <= '0;
            id_rd_q        <= '0;
            id_rs1_q       <= '0;
            id_rs2_q       <= '0;
            id_imm_q       <= '0;
            id_reg_write_q <= 1'b0;
            id_mem_read_q  <= 1'b0;
            id_mem_write_q <= 1'b0;
            id_is_branch_q <= 1'b0;
            id_illegal_q   <= 1'b0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
        end else if (branch_flush || hazard) begin
            id_valid_q     <= 1'b0;
            id_pc_q        <= '0;
            id_opcode_q    <= '0;
            id_rd_q        <= '0;
            id_rs1_q       <= '0;
            id_rs2_q       <= '0;
            id_imm_q       <= '0;
            id_reg_write_q <= 1'b0;
            id_mem_read_q  <= 1'b0;
            id_mem_write_q <= 1'b0;
            id_is_branch_q <= 1'b0;
            id_illegal_q   <= 1'b0;
            if (branch_flush) begin
                if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + STALL_CNT_W'(1);
            end else begin
                if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
            end
        end else begin
            id_valid_q     <= 1'b1;
            id_pc_q        <= pc;
            id_opcode_q    <= instr[15:12];
            id_rd_q        <= instr[11:8];
            id_rs1_q       <= instr[7:4];
            id_rs2_q       <= instr[3:0];
            id_imm_q       <= instr[7:0];
            id_reg_write_q <= dec_reg_write;
            id_mem_read_q  <= dec_mem_read;
            id_mem_write_q <= dec_mem_write;
            id_is_branch_q <= dec_is_branch;
            id_illegal_q   <= dec_illegal;
        end
    end

    assign id_valid     = id_valid_q;
    assign id_pc        = id_pc_q;
    assign id_opcode    = id_opcode_q;
    assign id_rd        = id_rd_q;
    assign id_rs1       = id_rs1_q;
    assign id_rs2       = id_rs2_q;
    assign id_imm       = id_imm_q;
    assign id_reg_write = id_reg_write_q;
    assign id_mem_read  = id_mem_read_q;
    assign id_mem_write = id_mem_write_q;
    assign id_is_branch = id_is_branch_q;
    assign id_illegal   = id_illegal_q;
    assign stall_count  = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: directed scenarios followed by
// randomized traffic, checked against an instruction-level reference model.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] IF_output = '0;
    logic        branch_flush = 1'b0;

    logic        data_stall, id_valid, id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_illegal;
    logic [7:0]  id_pc, id_imm;
    logic [3:0]  id_opcode, id_rd, id_rs1, id_rs2;
    logic [7:0]  stall_count, flush_count;

    logic        s2_stall, s2_valid, s2_rw, s2_mr, s2_mw, s2_br, s2_ill;
    logic [7:0]  s2_pc, s2_imm;
    logic [3:0]  s2_op, s2_rd, s2_rs1, s2_rs2;
    logic [1:0]  s2_sc, s2_fc;

    instruction_decode #(.STALL_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .IF_output(IF_output), .branch_flush(branch_flush),
        .data_stall(data_stall), .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_is_branch(id_is_branch), .id_illegal(id_illegal),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // narrow-counter instance to exercise saturation
    instruction_decode #(.STALL_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .IF_output(IF_output), .branch_flush(branch_flush),
        .data_stall(s2_stall), .id_valid(s2_valid), .id_pc(s2_pc), .id_opcode(s2_op),
        .id_rd(s2_rd), .id_rs1(s2_rs1), .id_rs2(s2_rs2), .id_imm(s2_imm),
        .id_reg_write(s2_rw), .id_mem_read(s2_mr), .id_mem_write(s2_mw),
        .id_is_branch(s2_br), .id_illegal(s2_ill),
        .stall_count(s2_sc), .flush_count(s2_fc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          stall;
        bit          valid;
        logic [7:0]  pc;
        logic [15:0] ins;
        int          sc;
        int          fc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_busy = 1'b0;

    // reference model state: contents of ID/EX as a whole instruction
    bit          m_valid = 1'b0;
    logic [7:0]  m_pc = '0;
    logic [15:0] m_ins = '0;
    int          m_sc = 0;
    int          m_fc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reads_reg(input logic [15:0] ins, input logic [3:0] r);
        case (ins[15:12])
            4'h1, 4'h2, 4'h3, 4'h4: return (ins[7:4] == r) || (ins[3:0] == r);
            4'h6:                   return ins[7:4] == r;
            4'h7:                   return (ins[7:4] == r) || (ins[11:8] == r);
            4'h9:                   return ins[11:8] == r;
            default:                return 1'b0;
        endcase
    endfunction

    // {reg_write, mem_read, mem_write, is_branch, illegal}
    function automatic logic [4:0] flags_of(input logic [3:0] op);
        if (op >= 4'h1 && op <= 4'h5) return 5'b10000;
        if (op == 4'h6)               return 5'b11000;
        if (op == 4'h7)               return 5'b00100;
        if (op == 4'h8 || op == 4'h9) return 5'b00010;
        if (op >= 4'hA)               return 5'b00001;
        return 5'b00000;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Drive one fetch bundle, advance the model, queue the expectation; returns expected stall
    task automatic present(input logic [7:0] pc, input logic [15:0] ins, input bit fl, output bit stall);
        exp_t e;
        IF_output    = {ins, pc};
        branch_flush = fl;
        stall = m_valid && (m_ins[15:12] == 4'h6) && !fl && reads_reg(ins, m_ins[11:8]);
        if (fl) begin
            m_valid = 0; m_pc = '0; m_ins = '0; m_fc++;
        end else if (stall) begin
            m_valid = 0; m_pc = '0; m_ins = '0; m_sc++;
        end else begin
            m_valid = 1; m_pc = pc; m_ins = ins;
        end
        e.stall = stall; e.valid = m_valid; e.pc = m_pc; e.ins = m_ins; e.sc = m_sc; e.fc = m_fc;
        q.push_back(e);
    endtask

    task automatic apply(input logic [7:0] pc, input logic [15:0] ins, input bit fl);
        bit s;
        @(posedge clk); #1;
        present(pc, ins, fl, s);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, id_valid, 0);
        chk({tag, "_stall"}, data_stall, 0);
        chk({tag, "_fields"}, {id_pc, id_opcode, id_rd, id_rs1, id_rs2, id_imm}, 0);
        chk({tag, "_flags"}, {id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_illegal}, 0);
        chk({tag, "_counts"}, {stall_count, flush_count}, 0);
        chk({tag, "_counts_w2"}, {s2_sc, s2_fc, s2_valid}, 0);
    endtask

    // Monitor: stall is checked mid-cycle, registered outputs just after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0 && !rst) begin
                mon_busy = 1'b1;
                e = q.pop_front();
                chk("data_stall", data_stall, e.stall);
                @(posedge clk); #2;
                chk("id_valid", id_valid, e.valid);
                chk("id_pc", id_pc, e.pc);
                chk("id_opcode", id_opcode, e.ins[15:12]);
                chk("id_rd", id_rd, e.ins[11:8]);
                chk("id_rs1", id_rs1, e.ins[7:4]);
                chk("id_rs2", id_rs2, e.ins[3:0]);
                chk("id_imm", id_imm, e.ins[7:0]);
                chk("flags", {id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_illegal},
                    e.valid ? flags_of(e.ins[15:12]) : 5'b0);
                chk("stall_count", stall_count, e.sc);
                chk("flush_count", flush_count, e.fc);
                chk("stall_count_w2", s2_sc, sat3(e.sc));
                chk("flush_count_w2", s2_fc, sat3(e.fc));
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          s;
        logic [15:0] ins;
        logic [7:0]  pc;
        logic [3:0]  op;

        // reset state
        repeat (2) @(posedge clk);
        #2 check_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        // LDI R0,0x12
        apply(8'h00, 16'h5012, 0);
        // load-use: one stall then ADD latches
        apply(8'h01, 16'h6310, 0);
        apply(8'h02, 16'h1432, 0);
        apply(8'h02, 16'h1432, 0);
        // LOAD then LDI to same reg: no stall
        apply(8'h03, 16'h6310, 0);
        apply(8'h04, 16'h5305, 0);
        // flush beats hazard
        apply(8'h05, 16'h6310, 0);
        apply(8'h06, 16'h1432, 1);
        apply(8'h07, 16'h1432, 0);
        // illegal opcode
        apply(8'h08, 16'hF000, 0);
        // back-to-back loads to R3, then one dependent consumer
        apply(8'h09, 16'h6310, 0);
        apply(8'h0A, 16'h6310, 0);
        apply(8'h0B, 16'h9340, 0);
        apply(8'h0B, 16'h9340, 0);
        // repeated load-use stalls to saturate the narrow counter
        for (int i = 0; i < 5; i++) begin
            apply(8'h10 + 8'(i), 16'h6310, 0);
            apply(8'h20 + 8'(i), 16'h7305, 0);
            apply(8'h20 + 8'(i), 16'h7305, 0);
        end

        // asynchronous reset while a stall is being signalled
        apply(8'h30, 16'h6310, 0);
        @(posedge clk); #1;
        IF_output = {16'h1432, 8'h31};
        #2 chk("stall_before_rst", data_stall, 1'b1);
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        m_valid = 0; m_pc = '0; m_ins = '0; m_sc = 0; m_fc = 0;
        present(8'h31, 16'h1432, 0, s);

        // randomized traffic; fetch re-presents an instruction that stalled
        pc = 8'h40;
        ins = 16'h0000;
        s = 0;
        for (int i = 0; i < 400; i++) begin
            if (!s) begin
                op = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
                ins = {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
                pc = pc + 8'd1;
            end
            @(posedge clk); #1;
            present(pc, ins, ($urandom_range(0, 7) == 0), s);
        end

        // let the scoreboard drain
        for (int i = 0; i < 20 && (q.size() != 0 || mon_busy); i++) @(posedge clk);
        #3;
        chk("scoreboard_drained", {31'b0, (q.size() != 0 || mon_busy)}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
